// File: rtl/fp32_to_int_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_to_int_seq
//  Description : Sequential fp32 -> signed int32 converter (truncate, saturate),
//                aligning the mantissa one bit per cycle.
//  Revision    : 1.0
// ============================================================================
module fp32_to_int_seq #(
    parameter int BIAS   = 127,
    parameter int MANT_W = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] o,
    output logic        ovf,
    output logic        inexact
);

    localparam int c_EXP_W = 31 - MANT_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]        r_acc;
    logic [4:0]         r_cnt;
    logic               r_left;
    logic               r_sign;
    logic [31:0]        r_o;
    logic               r_ovf;
    logic               r_inexact;

    logic [c_EXP_W-1:0] w_exp;
    logic [MANT_W-1:0]  w_frac;
    logic [9:0]         w_e;
    logic               w_e_neg;
    logic               w_left;
    logic [9:0]         w_shamt;
    logic               w_sat;
    logic               w_min;
    logic               w_accept;

    assign w_exp    = x[30 -: c_EXP_W];
    assign w_frac   = x[MANT_W-1:0];
    assign w_e      = 10'(w_exp) - 10'(BIAS);
    assign w_e_neg  = w_e[9];
    assign w_left   = !w_e_neg && (w_e >= 10'(MANT_W));
    assign w_shamt  = w_left ? (w_e - 10'(MANT_W)) : (10'(MANT_W) - w_e);
    assign w_sat    = w_exp >= c_EXP_W'(BIAS + 31);
    assign w_min    = (x == 32'hCF00_0000);
    assign w_accept = in_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == 5'd0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Special cases preload the final magnitude with cnt=0 so every result
    // leaves through the same SHIFT->DONE step and shares one latency rule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_left    <= 1'b0;
            r_sign    <= 1'b0;
            r_o       <= '0;
            r_ovf     <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign    <= x[31];
                        r_ovf     <= 1'b0;
                        r_inexact <= 1'b0;
                        r_cnt     <= 5'd0;
                        r_left    <= 1'b1;
                        if (w_exp == '0) begin
                            r_acc     <= '0;
                            r_inexact <= |w_frac;
                        end else if (w_e_neg) begin
                            r_acc     <= '0;
                            r_inexact <= 1'b1;
                        end else if (w_min) begin
                            r_acc     <= 32'h8000_0000;
                        end else if (w_sat) begin
                            r_acc     <= x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                            r_ovf     <= 1'b1;
                        end else begin
                            r_acc     <= 32'(({1'b1, w_frac}));
                            r_cnt     <= w_shamt[4:0];
                            r_left    <= w_left;
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != 5'd0) begin
                        r_cnt <= r_cnt - 5'd1;
                        if (r_left) begin
                            r_acc <= {r_acc[30:0], 1'b0};
                        end else begin
                            r_acc     <= {1'b0, r_acc[31:1]};
                            r_inexact <= r_inexact | r_acc[0];
                        end
                    end else begin
                        r_o <= r_sign ? (~r_acc + 32'd1) : r_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o       = r_o;
    assign ovf     = r_ovf;
    assign inexact = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp32_to_int_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp32_to_int_seq
//  Description : Self-checking bench for fp32_to_int_seq (vector table,
//                scoreboard queue, backpressure and mid-shift reset sequences).
//  Revision    : 1.0
// ============================================================================
module tb_fp32_to_int_seq;

    typedef struct {
        logic [31:0] x;
        logic [31:0] o;
        logic        ovf;
        logic        inexact;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] x = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] o;
    logic        ovf;
    logic        inexact;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sb[$];
    vec_t vecs[16];

    always #5 clk = ~clk;

    fp32_to_int_seq #(.BIAS(127), .MANT_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .ovf       (ovf),
        .inexact   (inexact)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] xv, input logic [31:0] ov,
                                input logic fv, input logic iv, input int lv);
        vec_t v;
        v.x = xv; v.o = ov; v.ovf = fv; v.inexact = iv; v.lat = lv;
        return v;
    endfunction

    // Barrel-shift reference for normal-range operands.
    function automatic vec_t model(input logic [31:0] xv);
        vec_t        v;
        int          e;
        logic [63:0] m;
        logic [63:0] mag;
        e = int'(xv[30:23]) - 127;
        m = {40'd0, 1'b1, xv[22:0]};
        v.x = xv; v.ovf = 1'b0; v.inexact = 1'b0;
        if (e >= 23) begin
            mag   = m << (e - 23);
            v.lat = e - 23 + 1;
        end else begin
            mag       = m >> (23 - e);
            v.inexact = (m & ((64'd1 << (23 - e)) - 64'd1)) != 64'd0;
            v.lat     = 23 - e + 1;
        end
        v.o = xv[31] ? (32'd0 - mag[31:0]) : mag[31:0];
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int   lat;
        int   w;
        vec_t e;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        @(negedge clk);
        x = v.x; in_valid = 1'b1;
        sb.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0; x = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        check($sformatf("o[%h]", e.x), 64'(o), 64'(e.o));
        check($sformatf("ovf[%h]", e.x), 64'(ovf), 64'(e.ovf));
        check($sformatf("inexact[%h]", e.x), 64'(inexact), 64'(e.inexact));
        check($sformatf("latency[%h]", e.x), 64'(lat), 64'(e.lat));
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check($sformatf("idle_after_take[%h]", e.x), 64'({in_ready, out_valid}), 64'(2'b10));
    endtask

    initial begin
        vec_t e;
        int   w;
        vecs[0]  = mk(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 24);
        vecs[1]  = mk(32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b1, 23);
        vecs[2]  = mk(32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 1);
        vecs[3]  = mk(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        vecs[4]  = mk(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
        vecs[5]  = mk(32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        vecs[6]  = mk(32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 1);
        vecs[7]  = mk(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
        vecs[8]  = mk(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
        vecs[9]  = mk(32'h4E80_0000, 32'h4000_0000, 1'b0, 1'b0, 8);
        vecs[10] = mk(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1);
        vecs[11] = mk(32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0, 1);
        vecs[12] = mk(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1);
        vecs[13] = mk(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 8);
        vecs[14] = mk(32'hC2F6_E666, 32'hFFFF_FF85, 1'b0, 1'b1, 18);
        vecs[15] = mk(32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 24);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'({in_ready, out_valid, ovf, inexact, o}), 64'({4'b1000, 32'h0}));
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] xr;
            xr = {1'($urandom_range(0, 1)), 8'($urandom_range(127, 157)), 23'($urandom)};
            run_vec(model(xr));
        end

        // Backpressure: result must hold while out_ready stays low.
        @(negedge clk);
        x = 32'hC049_0FDB; in_valid = 1'b1;
        sb.push_back(vecs[1]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 200) begin
            @(posedge clk); #1; w++;
        end
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; x = 32'h3F80_0000;
            #1;
            check($sformatf("hold_cycle%0d", i),
                  64'({out_valid, in_ready, ovf, inexact, o}),
                  64'({1'b1, 1'b0, e.ovf, e.inexact, e.o}));
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_hold", 64'({in_ready, out_valid}), 64'(2'b10));
        run_vec(vecs[2]);

        // Reset mid-shift drops the conversion immediately.
        @(negedge clk);
        x = 32'h3F80_0000; in_valid = 1'b1;
        sb.push_back(vecs[0]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("busy_before_reset", 64'({in_ready, out_valid}), 64'(2'b00));
        rst = 1'b1;
        sb.delete();
        #1;
        check("async_reset", 64'({out_valid, in_ready, o}), 64'({2'b01, 32'h0}));
        @(negedge clk); rst = 1'b0;
        run_vec(vecs[0]);
        run_vec(vecs[14]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
